// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state, kind codes and default widths for the attractor sweep controller
package sweep_pkg;

   localparam int X_W_DEF       = 8;
   localparam int MAX_STEPS_DEF = 64;
   localparam int CLR_CYC_DEF   = 2;
   localparam int STEP_W        = 7;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      RUN,
      REPORT,
      DONE
   } sweep_state_t;

   localparam logic [1:0] KIND_FIX = 2'b00;
   localparam logic [1:0] KIND_CYC = 2'b01;
   localparam logic [1:0] KIND_TMO = 2'b10;

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - loadable saturating up-counter with terminal-count flag
module step_timer
#(
   parameter int W = 7
)
(
   input  logic         clk,
   input  logic         n_reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   input  logic [W-1:0] i_term,
   output logic [W-1:0] o_count,
   output logic         o_term
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != {W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_term  = (r_count == i_term);

endmodule

// File: rtl/attractor_sweep_ctrl.sv
// rtl/attractor_sweep_ctrl.sv - sweeps every initial state through the network and reports each outcome
// Define ATTR_SNAPSHOT_EN to add rec_attr, the network state captured in the outcome cycle.
module attractor_sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int X_W       = X_W_DEF,
   parameter int MAX_STEPS = MAX_STEPS_DEF,
   parameter int CLR_CYC   = CLR_CYC_DEF
)
(
   input  logic              clk,
   input  logic              n_reset,
   input  logic              start,
   input  logic              abort,
   input  logic [X_W-1:0]    first_x,
   input  logic [X_W-1:0]    last_x,
   input  logic              fix,
   input  logic              cycle,
   input  logic [X_W-1:0]    x_out,
   output logic [X_W-1:0]    x_in,
   output logic              net_n_reset,
   output logic              busy,
   output logic              done,
   output logic              rec_valid,
   input  logic              rec_ready,
   output logic [X_W-1:0]    rec_x,
   output logic [1:0]        rec_kind,
   output logic [STEP_W-1:0] rec_steps,
   output logic [X_W:0]      fix_cnt,
   output logic [X_W:0]      cyc_cnt,
   output logic [X_W:0]      tmo_cnt
`ifdef ATTR_SNAPSHOT_EN
   ,
   output logic [X_W-1:0]    rec_attr
`endif
);

   localparam logic [STEP_W-1:0] CLR_TERM = STEP_W'(CLR_CYC - 1);
   localparam logic [STEP_W-1:0] RUN_TERM = STEP_W'(MAX_STEPS - 1);

   sweep_state_t      r_state;
   sweep_state_t      w_next_state;
   logic [X_W-1:0]    r_x_in;
   logic [X_W-1:0]    r_last_x;
   logic              r_net_n_reset;
   logic              r_busy;
   logic              r_rec_valid;
   logic [X_W-1:0]    r_rec_x;
   logic [1:0]        r_rec_kind;
   logic [STEP_W-1:0] r_rec_steps;
   logic [X_W:0]      r_fix_cnt;
   logic [X_W:0]      r_cyc_cnt;
   logic [X_W:0]      r_tmo_cnt;

   logic              w_tmr_load;
   logic              w_tmr_en;
   logic              w_tmr_term;
   logic [STEP_W-1:0] w_tmr_term_val;
   logic [STEP_W-1:0] w_step;
   logic              w_outcome;
   logic              w_handshake;
   logic              w_last;
   logic [1:0]        w_kind;

   step_timer #(.W(STEP_W)) u_timer (
      .clk        (clk),
      .n_reset    (n_reset),
      .i_load     (w_tmr_load),
      .i_load_val ({STEP_W{1'b0}}),
      .i_en       (w_tmr_en),
      .i_term     (w_tmr_term_val),
      .o_count    (w_step),
      .o_term     (w_tmr_term)
   );

   // In RUN the terminal flag is the timeout; a detection in that same cycle still wins via w_kind.
   assign w_outcome   = fix || cycle || w_tmr_term;
   assign w_handshake = r_rec_valid && rec_ready;
   assign w_last      = (r_x_in == r_last_x);
   assign w_kind      = fix ? KIND_FIX : (cycle ? KIND_CYC : KIND_TMO);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state   = r_state;
      w_tmr_load     = 1'b0;
      w_tmr_en       = 1'b0;
      w_tmr_term_val = (r_state == RUN) ? RUN_TERM : CLR_TERM;
      if (abort) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  w_next_state = CLR;
                  w_tmr_load   = 1'b1;
               end
            end
            CLR: begin
               w_tmr_en = 1'b1;
               if (w_tmr_term) begin
                  w_next_state = RUN;
                  w_tmr_load   = 1'b1;
               end
            end
            RUN: begin
               w_tmr_en = 1'b1;
               if (w_outcome) begin
                  w_next_state = REPORT;
               end
            end
            REPORT: begin
               if (w_handshake) begin
                  if (w_last) begin
                     w_next_state = DONE;
                  end else begin
                     w_next_state = CLR;
                     w_tmr_load   = 1'b1;
                  end
               end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_x_in        <= '0;
         r_last_x      <= '0;
         r_net_n_reset <= 1'b0;
         r_busy        <= 1'b0;
         r_rec_valid   <= 1'b0;
         r_rec_x       <= '0;
         r_rec_kind    <= '0;
         r_rec_steps   <= '0;
         r_fix_cnt     <= '0;
         r_cyc_cnt     <= '0;
         r_tmo_cnt     <= '0;
      end else if (abort) begin
         r_rec_valid   <= 1'b0;
         r_net_n_reset <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_x_in    <= first_x;
                  r_last_x  <= last_x;
                  r_fix_cnt <= '0;
                  r_cyc_cnt <= '0;
                  r_tmo_cnt <= '0;
                  r_busy    <= 1'b1;
               end
            end
            CLR: begin
               if (w_tmr_term) begin
                  r_net_n_reset <= 1'b1;
               end
            end
            RUN: begin
               if (w_outcome) begin
                  r_rec_x       <= r_x_in;
                  r_rec_kind    <= w_kind;
                  r_rec_steps   <= w_step;
                  r_rec_valid   <= 1'b1;
                  r_net_n_reset <= 1'b0;
                  case (w_kind)
                     KIND_FIX: r_fix_cnt <= r_fix_cnt + 1'b1;
                     KIND_CYC: r_cyc_cnt <= r_cyc_cnt + 1'b1;
                     default:  r_tmo_cnt <= r_tmo_cnt + 1'b1;
                  endcase
               end
            end
            REPORT: begin
               if (w_handshake) begin
                  r_rec_valid <= 1'b0;
                  if (!w_last) begin
                     r_x_in <= r_x_in + 1'b1;
                  end
               end
            end
            DONE:    r_busy <= 1'b0;
            default: ;
         endcase
      end
   end

`ifdef ATTR_SNAPSHOT_EN
   logic [X_W-1:0] r_rec_attr;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_rec_attr <= '0;
      end else if (!abort && (r_state == RUN) && w_outcome) begin
         r_rec_attr <= x_out;
      end
   end

   assign rec_attr = r_rec_attr;
`else
   logic w_unused_x_out;
   assign w_unused_x_out = ^x_out;
`endif

   assign x_in        = r_x_in;
   assign net_n_reset = r_net_n_reset;
   assign busy        = r_busy;
   assign done        = (r_state == DONE);
   assign rec_valid   = r_rec_valid;
   assign rec_x       = r_rec_x;
   assign rec_kind    = r_rec_kind;
   assign rec_steps   = r_rec_steps;
   assign fix_cnt     = r_fix_cnt;
   assign cyc_cnt     = r_cyc_cnt;
   assign tmo_cnt     = r_tmo_cnt;

endmodule
